// File: rtl/readback_scheduler.sv
// Readback scheduler: after a capture, walks sample memory downward from the
// newest sample, handing one 32-bit word at a time to the serial transmitter
// and waiting for it to drain. Also forwards host ID requests while idle.
module readback_scheduler #(
  parameter int AW          = 13,
  parameter int MEM_LATENCY = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          run,
  input  logic          abort,
  input  logic [AW-1:0] startAddr,
  input  logic [AW:0]   sampleCount,
  input  logic          idRequest,
  output logic          memRead,
  output logic [AW-1:0] memAddr,
  input  logic [31:0]   memData,
  output logic [31:0]   txData,
  output logic          txWrite,
  output logic          txId,
  input  logic          txBusy,
  output logic          active,
  output logic          done
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] READ    = 3'd1;
  localparam logic [2:0] MEMWAIT = 3'd2;
  localparam logic [2:0] SEND    = 3'd3;
  localparam logic [2:0] HOLD    = 3'd4;
  localparam logic [2:0] DRAIN   = 3'd5;

  localparam logic [1:0] LAT_INIT = 2'(MEM_LATENCY);

  logic [2:0]  state;
  logic [AW:0] remaining;
  logic [1:0]  lat_cnt;
  logic        id_path;

  // Read and write strobes follow the state directly, so an abort or reset
  // drops them the moment the state leaves READ/SEND.
  always_comb begin
    memRead = (state == READ);
    txWrite = (state == SEND);
    active  = (state != IDLE);
  end

  // Sequencer: one sample per pass READ -> MEMWAIT -> SEND -> HOLD -> DRAIN.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      memAddr   <= '0;
      txData    <= '0;
      remaining <= '0;
      lat_cnt   <= '0;
      id_path   <= 1'b0;
      txId      <= 1'b0;
      done      <= 1'b0;
    end else begin
      txId <= 1'b0;
      done <= 1'b0;
      if (state != IDLE && abort) begin
        state <= IDLE;
        done  <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (run && !abort) begin
              memAddr   <= startAddr;
              remaining <= sampleCount;
              id_path   <= 1'b0;
              if (sampleCount == '0) done  <= 1'b1;
              else                   state <= READ;
            end else if (idRequest) begin
              // ID send reuses HOLD/DRAIN to wait out the transmitter
              txId    <= 1'b1;
              id_path <= 1'b1;
              state   <= HOLD;
            end
          end
          READ: begin
            lat_cnt <= LAT_INIT;
            state   <= MEMWAIT;
          end
          MEMWAIT: begin
            if (lat_cnt == 2'd1) begin
              txData <= memData;
              state  <= SEND;
            end else begin
              lat_cnt <= lat_cnt - 2'd1;
            end
          end
          SEND: begin
            memAddr   <= memAddr - AW'(1);
            remaining <= remaining - (AW+1)'(1);
            state     <= HOLD;
          end
          HOLD: begin
            // busy from the transmitter is registered; not yet valid here
            state <= DRAIN;
          end
          DRAIN: begin
            if (!txBusy) begin
              if (!id_path && remaining != '0) begin
                state <= READ;
              end else begin
                state <= IDLE;
                done  <= !id_path;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
